// File: rtl/spi_reg_peripheral.sv
// -----------------------------------------------------------------------------
// spi_reg_peripheral
//
// Write-only SPI mode-0 slave that feeds the PWM generator's control
// registers. The SPI pins are oversampled in the clk domain through
// synchroniser chains. Each 16-bit MSB-first frame {rw, addr[6:0], data[7:0]}
// is committed to one of five 8-bit registers when chip select rises.
//
// Ports:
//   clk              system clock (only clock in the block)
//   rst_n            asynchronous active-low reset
//   sclk, copi, ncs  raw SPI pins, asynchronous to clk
//   en_reg_out_7_0   register 0x00
//   en_reg_out_15_8  register 0x01
//   en_reg_pwm_7_0   register 0x02
//   en_reg_pwm_15_8  register 0x03
//   pwm_duty_cycle   register 0x04
//   txn_done         one-cycle pulse at the end of every frame
//   txn_err          one-cycle pulse with txn_done when the frame is discarded
// -----------------------------------------------------------------------------
module spi_reg_peripheral #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       txn_done,
    output logic       txn_err
);

    localparam logic [6:0] MAX_ADDR_C   = 7'(MAX_ADDR);
    localparam logic [4:0] FRAME_BITS_C = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // A frame is written only when exactly a full frame was captured, it is a
    // write, and it targets an implemented register.
    function automatic logic frame_is_valid(input logic [4:0] cnt, input logic [15:0] frame);
        return (cnt == FRAME_BITS_C) && frame[15] && (frame[14:8] <= MAX_ADDR_C);
    endfunction

    logic [SYNC_STAGES-1:0] ncs_sync_r;
    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] copi_sync_r;
    logic                   ncs_prev_r;
    logic                   sclk_prev_r;

    logic                   ncs_last_s;
    logic                   sclk_last_s;
    logic                   copi_last_s;
    logic                   ncs_rise_s;
    logic                   ncs_fall_s;
    logic                   sclk_rise_s;

    state_t                 state_r;
    state_t                 state_next_s;
    logic                   clear_s;
    logic                   shift_s;
    logic                   commit_s;
    logic                   valid_s;
    logic                   write_en_s;

    logic [4:0]             bit_cnt_r;
    logic [15:0]            shift_r;
    logic [7:0]             reg_file_r [0:4];
    logic                   txn_done_r;
    logic                   txn_err_r;

    // Synchroniser chains plus one "prev" flop per edge-detected pin.
    // ncs resets high (deselected) so a released bus shows no false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs_sync_r  <= {SYNC_STAGES{1'b1}};
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            copi_sync_r <= {SYNC_STAGES{1'b0}};
            ncs_prev_r  <= 1'b1;
            sclk_prev_r <= 1'b0;
        end else begin
            ncs_sync_r  <= {ncs_sync_r[SYNC_STAGES-2:0], ncs};
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
            copi_sync_r <= {copi_sync_r[SYNC_STAGES-2:0], copi};
            ncs_prev_r  <= ncs_sync_r[SYNC_STAGES-1];
            sclk_prev_r <= sclk_sync_r[SYNC_STAGES-1];
        end
    end

    assign ncs_last_s  = ncs_sync_r[SYNC_STAGES-1];
    assign sclk_last_s = sclk_sync_r[SYNC_STAGES-1];
    assign copi_last_s = copi_sync_r[SYNC_STAGES-1];
    assign ncs_rise_s  = ncs_last_s & ~ncs_prev_r;
    assign ncs_fall_s  = ~ncs_last_s & ncs_prev_r;
    assign sclk_rise_s = sclk_last_s & ~sclk_prev_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and datapath controls. In SHIFT the ncs rise is tested
    // first so a coincident sclk edge is dropped.
    always_comb begin
        state_next_s = state_r;
        clear_s      = 1'b0;
        shift_s      = 1'b0;
        commit_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ncs_fall_s) begin
                    state_next_s = ST_SHIFT;
                    clear_s      = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (ncs_rise_s) begin
                    state_next_s = ST_COMMIT;
                end else if (sclk_rise_s && (bit_cnt_r < FRAME_BITS_C)) begin
                    shift_s = 1'b1;
                end else begin
                    shift_s = 1'b0;
                end
            end
            ST_COMMIT: begin
                commit_s     = 1'b1;
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    assign valid_s    = frame_is_valid(bit_cnt_r, shift_r);
    assign write_en_s = commit_s & valid_s;

    // Bit counter (saturates at a full frame) and MSB-first shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r <= 5'd0;
            shift_r   <= 16'h0000;
        end else if (clear_s) begin
            bit_cnt_r <= 5'd0;
            shift_r   <= 16'h0000;
        end else if (shift_s) begin
            bit_cnt_r <= bit_cnt_r + 5'd1;
            shift_r   <= {shift_r[14:0], copi_last_s};
        end
    end

    // Control register file, loaded on the edge that leaves COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                reg_file_r[i] <= 8'h00;
            end
        end else if (write_en_s) begin
            case (shift_r[14:8])
                7'd0:    reg_file_r[0] <= shift_r[7:0];
                7'd1:    reg_file_r[1] <= shift_r[7:0];
                7'd2:    reg_file_r[2] <= shift_r[7:0];
                7'd3:    reg_file_r[3] <= shift_r[7:0];
                7'd4:    reg_file_r[4] <= shift_r[7:0];
                default: reg_file_r[0] <= reg_file_r[0];
            endcase
        end
    end

    // Transaction status pulses, registered so they line up with the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_done_r <= 1'b0;
            txn_err_r  <= 1'b0;
        end else begin
            txn_done_r <= commit_s;
            txn_err_r  <= commit_s & ~valid_s;
        end
    end

    assign en_reg_out_7_0  = reg_file_r[0];
    assign en_reg_out_15_8 = reg_file_r[1];
    assign en_reg_pwm_7_0  = reg_file_r[2];
    assign en_reg_pwm_15_8 = reg_file_r[3];
    assign pwm_duty_cycle  = reg_file_r[4];
    assign txn_done        = txn_done_r;
    assign txn_err         = txn_err_r;

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_peripheral
//
// Scoreboard bench for spi_reg_peripheral. Each frame pushes its expected
// outcome (error flag, cycle at which txn_done must appear, full register
// image). A monitor pops an entry on every txn_done pulse and compares.
// -----------------------------------------------------------------------------
module tb_spi_reg_peripheral;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       txn_done;
    logic       txn_err;

    typedef struct {
        logic        err;
        int          due;
        logic [39:0] regs;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    logic [7:0]  exp_regs [0:4];
    int          cyc;
    int          n_cmp;
    int          n_bad;

    spi_reg_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .txn_done        (txn_done),
        .txn_err         (txn_err)
    );

    // 100 MHz system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count active clock edges for latency checks.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    task automatic check_val(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [39:0] dut_regs();
        return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
    endfunction

    function automatic logic [39:0] model_regs();
        return {exp_regs[4], exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]};
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drop ncs and clock out nbits of frame, MSB first, sclk = clk/10.
    task automatic send_bits(input logic [31:0] frame, input int nbits);
        logic [31:0] f;
        f = frame;
        @(negedge clk);
        ncs = 1'b0;
        wait_clk(6);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = f[i];
            wait_clk(5);
            sclk = 1'b1;
            wait_clk(5);
            sclk = 1'b0;
        end
        wait_clk(5);
    endtask

    // Raise ncs and record what the commit must look like.
    task automatic end_frame(input logic [31:0] frame, input int nbits);
        sb_entry_t   e;
        logic [15:0] first16;
        logic        valid;
        first16 = (nbits >= 16) ? 16'(frame >> (nbits - 16)) : 16'h0000;
        valid   = (nbits >= 16) && first16[15] && (first16[14:8] <= 7'd4);
        if (valid) begin
            exp_regs[first16[10:8]] = first16[7:0];
        end
        ncs   = 1'b1;
        e.err  = ~valid;
        e.due  = cyc + 4;
        e.regs = model_regs();
        sb_q.push_back(e);
        wait_clk(12);
    endtask

    task automatic frame(input logic [31:0] f, input int nbits);
        send_bits(f, nbits);
        end_frame(f, nbits);
    endtask

    // Scoreboard consumer: every txn_done pulse must match the oldest entry.
    always @(negedge clk) begin
        sb_entry_t e;
        if (rst_n) begin
            if (txn_done) begin
                if (sb_q.size() == 0) begin
                    check_val("unexpected_done", {39'd0, txn_done}, 40'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_val("txn_err", {39'd0, txn_err}, {39'd0, e.err});
                    check_val("done_cycle", 40'(cyc), 40'(e.due));
                    check_val("regs", dut_regs(), e.regs);
                end
            end else begin
                check_val("err_without_done", {39'd0, txn_err}, 40'd0);
            end
        end
    end

    initial begin
        cyc   = 0;
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
        rst_n = 1'b0;
        sclk  = 1'b0;
        copi  = 1'b0;
        ncs   = 1'b1;
        wait_clk(3);
        check_val("rst_regs", dut_regs(), 40'd0);
        check_val("rst_done", {39'd0, txn_done}, 40'd0);
        check_val("rst_err", {39'd0, txn_err}, 40'd0);
        rst_n = 1'b1;
        wait_clk(10);
        check_val("idle_regs", dut_regs(), 40'd0);

        frame(32'h80F0, 16);
        frame(32'h8480, 16);
        frame(32'h8101, 16);
        frame(32'h85AA, 16);
        frame(32'h00FF, 16);
        frame(32'h823, 12);
        frame(32'h8355A, 20);

        // Reset in the middle of a frame: partial data lost, registers cleared.
        send_bits(32'h82, 8);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
        wait_clk(2);
        ncs  = 1'b1;
        sclk = 1'b0;
        wait_clk(2);
        check_val("midframe_rst_regs", dut_regs(), model_regs());
        rst_n = 1'b1;
        wait_clk(10);
        check_val("post_rst_regs", dut_regs(), 40'd0);
        frame(32'h8233, 16);

        wait_clk(30);
        check_val("sb_drained", 40'(sb_q.size()), 40'd0);
        check_val("final_regs", dut_regs(), model_regs());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
